row_package_feeder: RTL and testbench
=====================================

// Module: row_package_feeder
// PURPOSE
//  Producer side of the dot-product row interface. Fetches two operand rows from package-wide RAMs, zero-pads the tail package,
//  and streams NI-element packages to the dot-product engine (read_now level, no_of_multiples count).
//  Advances to the next row pair only after the engine raises prepare_my_new_input.
// PARAMETERS
//  NI      8   elements (32-bit floats) per package; must be even, 8 or 16
//  AW      10  RAM package-address width
//  NW      16  width of element-count and row-count inputs
// PORTS
//  clk                   in   1      rising-edge clock
//  reset                 in   1      synchronous, active-high
//  start                 in   1      1-cycle pulse; accepted only in IDLE
//  first_base            in   AW     package address of row 0, operand A
//  second_base           in   AW     package address of row 0, operand B
//  noe                   in   NW     elements per row (>=1)
//  no_of_rows            in   NW     row pairs to stream (>=1)
//  mem_rd_en             out  1      read strobe to both RAMs
//  mem_addr_a/mem_addr_b out  AW     package addresses
//  mem_rd_data_a/_b      in   32*NI  RAM data, valid 1 cycle after mem_rd_en
//  first_row_input       out  32*NI  package A to engine, element 0 in MSBs
//  second_row_input      out  32*NI  package B to engine
//  outsider_read_now     out  1      level: packages of current row are on the bus
//  no_of_multiples       out  32     packages per row = ceil(noe/NI)
//  prepare_my_new_input  in   1      engine request for next row
//  busy                  out  1      high from accepted start until done
//  done                  out  1      1-cycle pulse after last row handed over
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; row and package counters 0; pending-request flag 0. Takes effect mid-operation
//   with no flush; in-flight RAM data is discarded.
//  start latches bases, noe, no_of_rows; no_of_multiples <= ceil(noe/NI), stable until next start.
//   Use a (noe+NI-1)>>log2(NI) shift, no divider. Rows are contiguous: row r begins at base + r*no_of_multiples.
//  States: IDLE -> PRIME (issue read of package 0) -> LOAD (capture data) -> STREAM -> WAIT_REQ -> PRIME or DONE -> IDLE.
//  STREAM: every package is held 2 cycles, because the engine multiplies the upper half and then the lower half.
//   outsider_read_now stays high for exactly 2*no_of_multiples consecutive cycles.
//   The read for package k+1 is issued in the first hold cycle of package k. The captured data goes to the bus on the
//   following 2-cycle boundary, so the bus has no bubbles.
//  Tail padding: in the last package, element slots i >= noe - NI*(no_of_multiples-1) are forced to 32'h0 on both
//   outputs. A full last package gets no mask.
//  After the final hold cycle: read_now <= 0, buses <= 0, state WAIT_REQ. If rows remain, a rising edge of
//   prepare_my_new_input -> PRIME for the next row. Otherwise -> DONE: one-cycle done pulse, busy <= 0, then IDLE.
//  A prepare_my_new_input edge that arrives while still in STREAM sets the pending flag; WAIT_REQ consumes it at once.
//   Edges in IDLE are ignored.
//  A start pulse while busy is ignored. A start pulse coinciding with reset is ignored.
//  noe==0 or no_of_rows==0 at start: no streaming; done pulses the next cycle.
//  Latency: start -> first read_now high = 3 cycles (PRIME, LOAD, bus registered).
//  No combinational path from any input to any output.
// STRUCTURE
//  Shared package rpf_pkg: NI/AW constants, FSM state enum, WORD=32, PAD_WORD=32'h0.
//  One sub-module, tail_pad_mask: combinational, valid_count -> 32*NI mask; it is reused for A and B.
//  The FSM, counters and RAM interface live in the top module.
// TESTING
//  1. NI=8, noe=16, rows=1, RAM A=1.0, B=2.0: read_now high 4 cycles, 2 packages each held 2 cycles,
//     no_of_multiples=2, done 1 cycle after prepare.
//  2. noe=10, rows=1: no_of_multiples=2; second package has elements 2..7 == 0 on both buses; elements 0..1 match the RAM.
//  3. noe=8, rows=3, prepare pulsed 5 cycles after each read_now fall: three 2-cycle bursts at addresses base,
//     base+1, base+2; done follows the third prepare.
//  4. prepare pulsed during STREAM of row 0 (rows=2): row 1 PRIME starts the cycle after WAIT_REQ entry;
//     no second request is needed.
//  5. Reset asserted mid-STREAM of row 1: next cycle read_now=0, busy=0, buses=0. A new start afterwards streams
//     from the row-0 address.
//  6. start while busy, and start with noe=0: the first is ignored (busy unchanged); the second gives done one
//     cycle later with read_now never high.

Source files
------------

// File: rtl/row_package_feeder_pkg.sv
// Shared constants and FSM state type for the row package feeder.
package rpf_pkg;

  localparam int RPF_NI = 8;
  localparam int RPF_AW = 10;
  localparam int RPF_NW = 16;

  localparam int              WORD     = 32;
  localparam logic [WORD-1:0] PAD_WORD = 32'h0;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    LOAD,
    STREAM,
    WAIT_REQ,
    DONE
  } rpf_state_e;

endpackage

// File: rtl/row_package_feeder_if.sv
// Bundles the control, RAM and engine-side signals of the row package feeder.
interface row_package_feeder_if #(
  parameter int NI = rpf_pkg::RPF_NI,
  parameter int AW = rpf_pkg::RPF_AW,
  parameter int NW = rpf_pkg::RPF_NW
) ();

  logic               start;
  logic [AW-1:0]      first_base;
  logic [AW-1:0]      second_base;
  logic [NW-1:0]      noe;
  logic [NW-1:0]      no_of_rows;
  logic               busy;
  logic               done;

  logic               mem_rd_en;
  logic [AW-1:0]      mem_addr_a;
  logic [AW-1:0]      mem_addr_b;
  logic [32*NI-1:0]   mem_rd_data_a;
  logic [32*NI-1:0]   mem_rd_data_b;

  logic [32*NI-1:0]   first_row_input;
  logic [32*NI-1:0]   second_row_input;
  logic               outsider_read_now;
  logic [31:0]        no_of_multiples;
  logic               prepare_my_new_input;

  modport master (
    input  start, first_base, second_base, noe, no_of_rows,
    input  mem_rd_data_a, mem_rd_data_b, prepare_my_new_input,
    output busy, done, mem_rd_en, mem_addr_a, mem_addr_b,
    output first_row_input, second_row_input, outsider_read_now, no_of_multiples
  );

  modport slave (
    output start, first_base, second_base, noe, no_of_rows,
    output mem_rd_data_a, mem_rd_data_b, prepare_my_new_input,
    input  busy, done, mem_rd_en, mem_addr_a, mem_addr_b,
    input  first_row_input, second_row_input, outsider_read_now, no_of_multiples
  );

endinterface

// File: rtl/row_package_feeder_tail_pad_mask.sv
// Builds a per-element keep mask for one package: the first valid_count
// element slots (element 0 in the MSBs) are all-ones, the rest all-zeros.
module tail_pad_mask
  import rpf_pkg::*;
#(
  parameter int NI = RPF_NI,
  parameter int CW = $clog2(NI) + 1
) (
  input  logic [CW-1:0]      valid_count,
  output logic [WORD*NI-1:0] mask
);

  // Open one 32-bit lane per element slot below the valid count.
  always_comb begin
    mask = '0;
    for (int i = 0; i < NI; i++) begin
      if (CW'(i) < valid_count) begin
        mask[WORD*(NI-1-i) +: WORD] = '1;
      end
    end
  end

endmodule

// File: rtl/row_package_feeder.sv
// Row package feeder: reads operand rows A and B package by package from two
// RAMs, zero-pads the tail package and presents each package to the
// dot-product engine for two cycles. The next row pair is only fetched once
// the engine requests it with a rising edge on prepare_my_new_input.
module row_package_feeder
  import rpf_pkg::*;
#(
  parameter int NI = RPF_NI,
  parameter int AW = RPF_AW,
  parameter int NW = RPF_NW
) (
  input logic                  clk,
  input logic                  reset,
  row_package_feeder_if.master rpf
);

  localparam int              LOG2NI   = $clog2(NI);
  localparam int              CW       = LOG2NI + 1;
  localparam int              BW       = WORD * NI;
  localparam logic [BW-1:0]   PAD_FILL = {NI{PAD_WORD}};

  rpf_state_e    state;
  logic [NW-1:0] nom;
  logic [NW-1:0] rows_total;
  logic [NW-1:0] row_cnt;
  logic [NW-1:0] pkg_cnt;
  logic [NW-1:0] next_pkg;
  logic [NW-1:0] nom_calc;
  logic [NW:0]   noe_round;
  logic [CW-1:0] tail_count;
  logic [CW-1:0] tail_calc;
  logic [CW-1:0] mask_count;
  logic          phase;
  logic          pending;
  logic          prep_d;
  logic          prep_rise;
  logic          load_last;
  logic [BW-1:0] pad_mask;
  logic [BW-1:0] padded_a;
  logic [BW-1:0] padded_b;

  // Package count and tail size from the start operands, plus the padded view
  // of whatever RAM data is being captured into the bus this cycle.
  always_comb begin
    noe_round  = {1'b0, rpf.noe} + (NW+1)'(NI - 1);
    nom_calc   = NW'(noe_round >> LOG2NI);
    tail_calc  = (rpf.noe[LOG2NI-1:0] == '0) ? CW'(NI) : {1'b0, rpf.noe[LOG2NI-1:0]};
    prep_rise  = rpf.prepare_my_new_input & ~prep_d;
    next_pkg   = (state == LOAD) ? '0 : pkg_cnt + NW'(1);
    load_last  = (next_pkg == nom - NW'(1));
    mask_count = load_last ? tail_count : CW'(NI);
    padded_a   = (rpf.mem_rd_data_a & pad_mask) | (PAD_FILL & ~pad_mask);
    padded_b   = (rpf.mem_rd_data_b & pad_mask) | (PAD_FILL & ~pad_mask);
  end

  tail_pad_mask #(
    .NI (NI),
    .CW (CW)
  ) u_tail_pad_mask (
    .valid_count (mask_count),
    .mask        (pad_mask)
  );

  // Sequencer: start latch, RAM prefetch one package ahead, 2-cycle hold per
  // package, then wait for the engine before the next row or completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      nom                   <= '0;
      rows_total            <= '0;
      row_cnt               <= '0;
      pkg_cnt               <= '0;
      tail_count            <= '0;
      phase                 <= 1'b0;
      pending               <= 1'b0;
      prep_d                <= 1'b0;
      rpf.busy              <= 1'b0;
      rpf.done              <= 1'b0;
      rpf.mem_rd_en         <= 1'b0;
      rpf.mem_addr_a        <= '0;
      rpf.mem_addr_b        <= '0;
      rpf.first_row_input   <= '0;
      rpf.second_row_input  <= '0;
      rpf.outsider_read_now <= 1'b0;
      rpf.no_of_multiples   <= '0;
    end else begin
      prep_d <= rpf.prepare_my_new_input;
      case (state)
        IDLE: begin
          if (rpf.start) begin
            nom                 <= nom_calc;
            rpf.no_of_multiples <= 32'(nom_calc);
            tail_count          <= tail_calc;
            rows_total          <= rpf.no_of_rows;
            row_cnt             <= '0;
            pkg_cnt             <= '0;
            pending             <= 1'b0;
            rpf.mem_addr_a      <= rpf.first_base;
            rpf.mem_addr_b      <= rpf.second_base;
            if (rpf.noe == '0 || rpf.no_of_rows == '0) begin
              rpf.done <= 1'b1;
              state    <= DONE;
            end else begin
              rpf.busy      <= 1'b1;
              rpf.mem_rd_en <= 1'b1;
              state         <= PRIME;
            end
          end
        end
        PRIME: begin
          rpf.mem_rd_en <= 1'b0;
          state         <= LOAD;
        end
        LOAD: begin
          rpf.first_row_input   <= padded_a;
          rpf.second_row_input  <= padded_b;
          rpf.outsider_read_now <= 1'b1;
          pkg_cnt               <= '0;
          phase                 <= 1'b0;
          state                 <= STREAM;
          if (!load_last) begin
            rpf.mem_rd_en  <= 1'b1;
            rpf.mem_addr_a <= rpf.mem_addr_a + AW'(1);
            rpf.mem_addr_b <= rpf.mem_addr_b + AW'(1);
          end
          if (prep_rise) begin
            pending <= pending;
          end
        end
        STREAM: begin
          if (prep_rise) begin
            pending <= 1'b1;
          end
          if (!phase) begin
            phase         <= 1'b1;
            rpf.mem_rd_en <= 1'b0;
          end else begin
            phase <= 1'b0;
            if (pkg_cnt == nom - NW'(1)) begin
              rpf.outsider_read_now <= 1'b0;
              rpf.first_row_input   <= '0;
              rpf.second_row_input  <= '0;
              row_cnt               <= row_cnt + NW'(1);
              state                 <= WAIT_REQ;
            end else begin
              rpf.first_row_input  <= padded_a;
              rpf.second_row_input <= padded_b;
              pkg_cnt              <= next_pkg;
              if (!load_last) begin
                rpf.mem_rd_en  <= 1'b1;
                rpf.mem_addr_a <= rpf.mem_addr_a + AW'(1);
                rpf.mem_addr_b <= rpf.mem_addr_b + AW'(1);
              end
            end
          end
        end
        WAIT_REQ: begin
          if (pending || prep_rise) begin
            pending <= 1'b0;
            if (row_cnt < rows_total) begin
              rpf.mem_rd_en  <= 1'b1;
              rpf.mem_addr_a <= rpf.mem_addr_a + AW'(1);
              rpf.mem_addr_b <= rpf.mem_addr_b + AW'(1);
              state          <= PRIME;
            end else begin
              rpf.done <= 1'b1;
              rpf.busy <= 1'b0;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          rpf.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_row_package_feeder.sv
// Self-checking bench for row_package_feeder: a RAM model, a package-level
// reference model of the expected bus beats and burst lengths, and directed
// scenarios with hand-computed values.
module tb_row_package_feeder;

  localparam int NI = 8;
  localparam int AW = 10;
  localparam int NW = 16;
  localparam int BW = 32 * NI;

  typedef struct packed {
    logic [BW-1:0] a;
    logic [BW-1:0] b;
  } beat_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  row_package_feeder_if #(.NI(NI), .AW(AW), .NW(NW)) dut_if ();

  row_package_feeder #(.NI(NI), .AW(AW), .NW(NW)) dut (
    .clk   (clk),
    .reset (reset),
    .rpf   (dut_if)
  );

  logic [BW-1:0] ram_a [0:1023];
  logic [BW-1:0] ram_b [0:1023];
  beat_t         expq[$];
  int            blen[$];
  int            checks  = 0;
  int            errors  = 0;
  bit            chk_en  = 1'b0;
  int            run_len = 0;

  // RAM pair: data one cycle after the strobe, garbage otherwise
  always @(posedge clk) begin
    if (dut_if.mem_rd_en === 1'b1) begin
      dut_if.mem_rd_data_a <= ram_a[dut_if.mem_addr_a];
      dut_if.mem_rd_data_b <= ram_b[dut_if.mem_addr_b];
    end else begin
      dut_if.mem_rd_data_a <= {NI{32'hDEADBEEF}};
      dut_if.mem_rd_data_b <= {NI{32'hBAADF00D}};
    end
  end

  task automatic checkOutput(input string name, input logic [BW-1:0] actual,
                             input logic [BW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Element e of row package p is kept if its global index is below noe
  function automatic logic [BW-1:0] expectedPackage(input bit side_b, input int addr,
                                                    input int pkg, input int n);
    logic [BW-1:0] src;
    logic [BW-1:0] res;
    src = side_b ? ram_b[addr] : ram_a[addr];
    res = '0;
    for (int i = 0; i < NI; i++) begin
      if (pkg * NI + i < n) res[BW-1-32*i -: 32] = src[BW-1-32*i -: 32];
    end
    return res;
  endfunction

  task automatic pulseStart(input int fa, input int fb, input int n, input int rows);
    dut_if.first_base  = AW'(fa);
    dut_if.second_base = AW'(fb);
    dut_if.noe         = NW'(n);
    dut_if.no_of_rows  = NW'(rows);
    dut_if.start       = 1'b1;
    tick(1);
    dut_if.start       = 1'b0;
  endtask

  task automatic applyStimulus(input int fa, input int fb, input int n, input int rows);
    int    packages;
    beat_t bt;
    if (n > 0 && rows > 0) begin
      packages = (n + NI - 1) / NI;
      for (int r = 0; r < rows; r++) begin
        for (int k = 0; k < packages; k++) begin
          bt.a = expectedPackage(1'b0, fa + r * packages + k, k, n);
          bt.b = expectedPackage(1'b1, fb + r * packages + k, k, n);
          expq.push_back(bt);
          expq.push_back(bt);
        end
        blen.push_back(2 * packages);
      end
    end
    pulseStart(fa, fb, n, rows);
  endtask

  task automatic pulsePrepare();
    dut_if.prepare_my_new_input = 1'b1;
    tick(1);
    dut_if.prepare_my_new_input = 1'b0;
  endtask

  task automatic waitLevel(input logic level, input string name, output int n);
    n = 0;
    while (dut_if.outsider_read_now !== level && n < 200) begin
      tick(1);
      n++;
    end
    if (dut_if.outsider_read_now !== level) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: read_now is %0b, expected %0b within 200 cycles",
               name, dut_if.outsider_read_now, level);
    end
  endtask

  // Compare process: every beat against the model, burst lengths, idle buses
  initial begin
    beat_t b;
    int    want;
    forever begin
      @(negedge clk);
      if (!chk_en) begin
        run_len = 0;
      end else if (dut_if.outsider_read_now === 1'b1) begin
        run_len++;
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat: read_now high, expected no beat");
        end else begin
          b = expq.pop_front();
          checkOutput("beat_a", dut_if.first_row_input, b.a);
          checkOutput("beat_b", dut_if.second_row_input, b.b);
        end
      end else begin
        if (run_len != 0) begin
          if (blen.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_burst: burst of %0d, expected none", run_len);
          end else begin
            want = blen.pop_front();
            checkOutput("burst_len", BW'(run_len), BW'(want));
          end
          run_len = 0;
        end
        checkOutput("idle_bus_a", dut_if.first_row_input, '0);
        checkOutput("idle_bus_b", dut_if.second_row_input, '0);
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int            n;
    logic [BW-1:0] lit_a;
    logic [BW-1:0] lit_b;

    reset                       = 1'b1;
    dut_if.start                = 1'b0;
    dut_if.prepare_my_new_input = 1'b0;
    dut_if.first_base           = '0;
    dut_if.second_base          = '0;
    dut_if.noe                  = '0;
    dut_if.no_of_rows           = '0;
    for (int a = 0; a < 1024; a++) begin
      for (int i = 0; i < NI; i++) begin
        ram_a[a][BW-1-32*i -: 32] = 32'hA0000000 | 32'(a << 8) | 32'(i);
        ram_b[a][BW-1-32*i -: 32] = 32'hB0000000 | 32'(a << 8) | 32'(i);
      end
    end
    ram_a[16] = {NI{32'h3F800000}};
    ram_a[17] = {NI{32'h3F800000}};
    ram_b[32] = {NI{32'h40000000}};
    ram_b[33] = {NI{32'h40000000}};

    tick(3);
    reset = 1'b0;
    tick(1);
    $display("[TB] reset state");
    checkOutput("reset_read_now", BW'(dut_if.outsider_read_now), '0);
    checkOutput("reset_busy", BW'(dut_if.busy), '0);
    checkOutput("reset_done", BW'(dut_if.done), '0);
    checkOutput("reset_nom", BW'(dut_if.no_of_multiples), '0);
    checkOutput("reset_rd_en", BW'(dut_if.mem_rd_en), '0);
    chk_en = 1'b1;

    $display("[TB] start coinciding with reset");
    reset        = 1'b1;
    dut_if.start = 1'b1;
    dut_if.noe   = NW'(8);
    dut_if.no_of_rows = NW'(1);
    tick(1);
    reset        = 1'b0;
    dut_if.start = 1'b0;
    tick(1);
    checkOutput("rst_start_busy", BW'(dut_if.busy), '0);
    checkOutput("rst_start_rd_en", BW'(dut_if.mem_rd_en), '0);

    $display("[TB] test 1: noe=16 rows=1");
    applyStimulus(16, 32, 16, 1);
    checkOutput("t1_busy", BW'(dut_if.busy), BW'(1));
    waitLevel(1'b1, "t1_rise", n);
    checkOutput("t1_latency", BW'(n + 1), BW'(3));
    checkOutput("t1_nom", BW'(dut_if.no_of_multiples), BW'(2));
    lit_a = {NI{32'h3F800000}};
    lit_b = {NI{32'h40000000}};
    checkOutput("t1_pkg0_a", dut_if.first_row_input, lit_a);
    checkOutput("t1_pkg0_b", dut_if.second_row_input, lit_b);
    waitLevel(1'b0, "t1_fall", n);
    checkOutput("t1_stream_cycles", BW'(n), BW'(4));
    tick(2);
    pulsePrepare();
    checkOutput("t1_done", BW'(dut_if.done), BW'(1));
    checkOutput("t1_busy_off", BW'(dut_if.busy), '0);
    tick(1);
    checkOutput("t1_done_pulse", BW'(dut_if.done), '0);

    $display("[TB] test 2: noe=10 tail padding");
    applyStimulus(64, 80, 10, 1);
    waitLevel(1'b1, "t2_rise", n);
    checkOutput("t2_nom", BW'(dut_if.no_of_multiples), BW'(2));
    tick(2);
    lit_a = {32'hA0004100, 32'hA0004101, 192'h0};
    lit_b = {32'hB0005100, 32'hB0005101, 192'h0};
    checkOutput("t2_tail_a", dut_if.first_row_input, lit_a);
    checkOutput("t2_tail_b", dut_if.second_row_input, lit_b);
    waitLevel(1'b0, "t2_fall", n);
    pulsePrepare();
    checkOutput("t2_done", BW'(dut_if.done), BW'(1));
    tick(1);

    $display("[TB] test 3: noe=8 rows=3");
    applyStimulus(256, 512, 8, 3);
    for (int r = 0; r < 3; r++) begin
      waitLevel(1'b1, "t3_rise", n);
      waitLevel(1'b0, "t3_fall", n);
      checkOutput("t3_burst_cycles", BW'(n), BW'(2));
      tick(4);
      pulsePrepare();
      if (r < 2) begin
        checkOutput("t3_no_done", BW'(dut_if.done), '0);
        checkOutput("t3_prime_rd_en", BW'(dut_if.mem_rd_en), BW'(1));
        checkOutput("t3_prime_addr", BW'(dut_if.mem_addr_a), BW'(256 + r + 1));
      end else begin
        checkOutput("t3_done", BW'(dut_if.done), BW'(1));
      end
    end
    tick(1);

    $display("[TB] test 4: early prepare during stream");
    applyStimulus(768, 896, 16, 2);
    waitLevel(1'b1, "t4_rise", n);
    tick(1);
    pulsePrepare();
    waitLevel(1'b0, "t4_fall", n);
    tick(1);
    checkOutput("t4_prime_rd_en", BW'(dut_if.mem_rd_en), BW'(1));
    checkOutput("t4_prime_addr", BW'(dut_if.mem_addr_a), BW'(770));
    waitLevel(1'b1, "t4_rise1", n);
    checkOutput("t4_row1_latency", BW'(n), BW'(2));
    waitLevel(1'b0, "t4_fall1", n);
    checkOutput("t4_no_done_yet", BW'(dut_if.done), '0);
    pulsePrepare();
    checkOutput("t4_done", BW'(dut_if.done), BW'(1));
    tick(1);

    $display("[TB] test 5: reset during row 1");
    applyStimulus(384, 448, 8, 2);
    waitLevel(1'b1, "t5_rise", n);
    waitLevel(1'b0, "t5_fall", n);
    tick(2);
    pulsePrepare();
    waitLevel(1'b1, "t5_rise1", n);
    tick(1);
    chk_en = 1'b0;
    reset  = 1'b1;
    tick(1);
    checkOutput("t5_read_now", BW'(dut_if.outsider_read_now), '0);
    checkOutput("t5_busy", BW'(dut_if.busy), '0);
    checkOutput("t5_bus_a", dut_if.first_row_input, '0);
    checkOutput("t5_bus_b", dut_if.second_row_input, '0);
    reset = 1'b0;
    expq.delete();
    blen.delete();
    tick(1);
    chk_en = 1'b1;
    applyStimulus(384, 448, 8, 1);
    checkOutput("t5_restart_addr_a", BW'(dut_if.mem_addr_a), BW'(384));
    checkOutput("t5_restart_addr_b", BW'(dut_if.mem_addr_b), BW'(448));
    waitLevel(1'b1, "t5_rise2", n);
    waitLevel(1'b0, "t5_fall2", n);
    pulsePrepare();
    checkOutput("t5_done", BW'(dut_if.done), BW'(1));
    tick(1);

    $display("[TB] test 6: start while busy, zero counts");
    applyStimulus(96, 112, 8, 1);
    waitLevel(1'b1, "t6_rise", n);
    pulseStart(0, 0, 16, 4);
    checkOutput("t6_busy_kept", BW'(dut_if.busy), BW'(1));
    checkOutput("t6_nom_kept", BW'(dut_if.no_of_multiples), BW'(1));
    waitLevel(1'b0, "t6_fall", n);
    pulsePrepare();
    checkOutput("t6_done", BW'(dut_if.done), BW'(1));
    tick(1);
    applyStimulus(5, 5, 0, 1);
    checkOutput("t6_noe0_done", BW'(dut_if.done), BW'(1));
    checkOutput("t6_noe0_busy", BW'(dut_if.busy), '0);
    tick(1);
    checkOutput("t6_noe0_done_pulse", BW'(dut_if.done), '0);
    tick(3);
    checkOutput("t6_noe0_read_now", BW'(dut_if.outsider_read_now), '0);
    applyStimulus(5, 5, 8, 0);
    checkOutput("t6_rows0_done", BW'(dut_if.done), BW'(1));
    tick(4);

    checkOutput("model_beats_drained", BW'(expq.size()), '0);
    checkOutput("model_bursts_drained", BW'(blen.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
